// File: rtl/eq_pkg.sv
// Shared definitions for the equalizer gain sequencer: register map,
// controller state encoding, status bit positions and the read-error word.
package eq_pkg;

    // Register byte offsets, decoded from adr[7:0]
    localparam logic [7:0] EQ_TGTB = 8'h00;
    localparam logic [7:0] EQ_TGTH = 8'h04;
    localparam logic [7:0] EQ_DIV  = 8'h08;
    localparam logic [7:0] EQ_CTRL = 8'h0C;
    localparam logic [7:0] EQ_STAT = 8'h10;
    localparam logic [7:0] EQ_CNT  = 8'h14;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        UPDATE = 2'd2
    } state_t;

    // Status register layout
    localparam int ST_BUSY = 0;
    localparam int ST_RAMP = 1;
    localparam int ST_OVR  = 2;
    localparam int ST_TMO  = 3;
    localparam int ST_GB   = 4;
    localparam int ST_GH   = 8;

    // Returned for reads of unmapped addresses
    localparam logic [31:0] RD_ERR = 32'hFF;

endpackage

// File: rtl/eq_gain_sequencer_if.sv
// Wishbone slave bus bundle for the gain sequencer.
//   master: drives stb/cyc/we/adr/sel/dat_i, receives dat_o/ack
//   slave : the reverse
interface eq_gain_sequencer_if;
    logic        wb_stb_i;
    logic        wb_cyc_i;
    logic        wb_we_i;
    logic [31:0] wb_adr_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;

    modport master (
        output wb_stb_i, wb_cyc_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_stb_i, wb_cyc_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
        output wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/eq_gain_ramp.sv
// One gain control: holds the current gain and its software target.
// Ports:
//   clk, reset        clock, async active-high reset
//   tgt_we, tgt_wdata target register write
//   step              move gain one unit toward target (saturates at target)
//   jump              load gain straight from target (takes priority over step)
//   gain, tgt         current gain and target
module eq_gain_ramp #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         tgt_we,
    input  logic [W-1:0] tgt_wdata,
    input  logic         step,
    input  logic         jump,
    output logic [W-1:0] gain,
    output logic [W-1:0] tgt
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gain <= '0;
            tgt  <= '0;
        end else begin
            if (tgt_we)
                tgt <= tgt_wdata;
            // A step always uses the target held before this cycle's write,
            // so a mid-ramp retarget takes effect at the following step.
            if (jump)
                gain <= tgt;
            else if (step) begin
                if (gain < tgt)
                    gain <= gain + 1'b1;
                else if (gain > tgt)
                    gain <= gain - 1'b1;
            end
        end
    end

endmodule

// File: rtl/eq_gain_sequencer.sv
// Equalizer gain sequencer: admits one ADC sample at a time into the
// equalizer datapath, waits for its completion strobe (with timeout), and
// ramps the bass/high gains toward software targets between samples.
// Ports:
//   clk, reset       clock, async active-high reset
//   RDYin            new ADC sample pulse
//   RDYeq            datapath completion pulse
//   sample_go        registered pulse forwarding an admitted sample
//   gainb, gainh     gain controls to the datapath
//   irq              registered level interrupt
//   wb               Wishbone slave (1 wait state, registered read data)
module eq_gain_sequencer
    import eq_pkg::*;
#(
    parameter int GAIN_W  = 3,
    parameter int TIMEOUT = 1023,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RDYin,
    input  logic              RDYeq,
    output logic              sample_go,
    output logic [GAIN_W-1:0] gainb,
    output logic [GAIN_W-1:0] gainh,
    output logic              irq,
    eq_gain_sequencer_if.slave wb
);

    localparam int TW = $clog2(TIMEOUT + 1);

    state_t            state, state_nx;
    logic [TW-1:0]     tmo_cnt;
    logic [7:0]        div, div_cnt;
    logic [CNT_W-1:0]  cnt;
    logic              ovr, tmo, irq_en, bypass;
    logic              ack_q;
    logic [GAIN_W-1:0] tgt_b, tgt_h;
    logic [31:0]       status, rdata;

    logic issue, complete, tmo_hit, upd;

    // Bus access acts only on the first strobe cycle; ack follows one later.
    logic       acc, wr, rd;
    logic [7:0] a;
    assign a   = wb.wb_adr_i[7:0];
    assign acc = wb.wb_stb_i & wb.wb_cyc_i & ~ack_q;
    assign wr  = acc & wb.wb_we_i;
    assign rd  = acc & ~wb.wb_we_i;
    assign wb.wb_ack_o = wb.wb_stb_i & wb.wb_cyc_i & ack_q;

    logic unused_bits;
    assign unused_bits = ^{wb.wb_adr_i[31:8], wb.wb_sel_i, wb.wb_dat_i[31:8]};

    // ---------------- controller FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        issue    = 1'b0;
        complete = 1'b0;
        tmo_hit  = 1'b0;
        upd      = 1'b0;
        case (state)
            IDLE: if (RDYin) begin
                issue    = 1'b1;
                state_nx = WAIT;
            end
            WAIT: begin
                // Completion wins over a timeout landing on the same cycle.
                if (RDYeq) begin
                    complete = 1'b1;
                    state_nx = UPDATE;
                end else if (tmo_cnt == TW'(TIMEOUT)) begin
                    tmo_hit  = 1'b1;
                    state_nx = IDLE;
                end
            end
            UPDATE: begin
                upd      = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // A sample arriving while one is in flight (or gains are updating) is dropped.
    logic ovr_set;
    assign ovr_set = RDYin & (state != IDLE);

    // ---------------- gain ramps ----------------
    logic do_step, do_jump;
    assign do_step = upd & (div_cnt == 8'd1);
    assign do_jump = upd & bypass;

    eq_gain_ramp #(.W(GAIN_W)) u_ramp_b (
        .clk       (clk),
        .reset     (reset),
        .tgt_we    (wr && a == EQ_TGTB),
        .tgt_wdata (wb.wb_dat_i[GAIN_W-1:0]),
        .step      (do_step),
        .jump      (do_jump),
        .gain      (gainb),
        .tgt       (tgt_b)
    );

    eq_gain_ramp #(.W(GAIN_W)) u_ramp_h (
        .clk       (clk),
        .reset     (reset),
        .tgt_we    (wr && a == EQ_TGTH),
        .tgt_wdata (wb.wb_dat_i[GAIN_W-1:0]),
        .step      (do_step),
        .jump      (do_jump),
        .gain      (gainh),
        .tgt       (tgt_h)
    );

    // ---------------- registers ----------------
    logic [7:0] div_wdata;
    assign div_wdata = (wb.wb_dat_i[7:0] == 8'd0) ? 8'd1 : wb.wb_dat_i[7:0];

    logic clr_ovr, clr_tmo;
    assign clr_ovr = wr && (a == EQ_STAT) && wb.wb_dat_i[ST_OVR];
    assign clr_tmo = wr && (a == EQ_STAT) && wb.wb_dat_i[ST_TMO];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt   <= '0;
            div       <= 8'd1;
            div_cnt   <= 8'd1;
            cnt       <= '0;
            ovr       <= 1'b0;
            tmo       <= 1'b0;
            irq_en    <= 1'b0;
            bypass    <= 1'b0;
            sample_go <= 1'b0;
            irq       <= 1'b0;
            ack_q     <= 1'b0;
            wb.wb_dat_o <= '0;
        end else begin
            sample_go <= issue;
            ack_q     <= wb.wb_stb_i & wb.wb_cyc_i;

            if (issue)
                tmo_cnt <= '0;
            else if (state == WAIT && !complete && !tmo_hit)
                tmo_cnt <= tmo_cnt + 1'b1;

            if (complete)
                cnt <= cnt + 1'b1;

            // Divider write reloads the step countdown.
            if (wr && a == EQ_DIV) begin
                div     <= div_wdata;
                div_cnt <= div_wdata;
            end else if (upd) begin
                if (div_cnt == 8'd1) div_cnt <= div;
                else                 div_cnt <= div_cnt - 1'b1;
            end

            if (wr && a == EQ_CTRL) begin
                irq_en <= wb.wb_dat_i[0];
                bypass <= wb.wb_dat_i[1];
            end

            // Hardware set beats a same-cycle software clear.
            ovr <= ovr_set | (ovr & ~clr_ovr);
            tmo <= tmo_hit | (tmo & ~clr_tmo);
            irq <= irq_en & (ovr | tmo);

            if (rd)
                wb.wb_dat_o <= rdata;
        end
    end

    // ---------------- read mux ----------------
    always_comb begin
        status = '0;
        status[ST_BUSY] = (state != IDLE);
        status[ST_RAMP] = (gainb != tgt_b) | (gainh != tgt_h);
        status[ST_OVR]  = ovr;
        status[ST_TMO]  = tmo;
        status[ST_GB +: GAIN_W] = gainb;
        status[ST_GH +: GAIN_W] = gainh;
    end

    always_comb begin
        rdata = RD_ERR;
        case (a)
            EQ_TGTB: rdata = 32'(tgt_b);
            EQ_TGTH: rdata = 32'(tgt_h);
            EQ_DIV:  rdata = 32'(div);
            EQ_CTRL: rdata = {30'd0, bypass, irq_en};
            EQ_STAT: rdata = status;
            EQ_CNT:  rdata = 32'(cnt);
            default: rdata = RD_ERR;
        endcase
    end

endmodule

// File: tb/tb_eq_gain_sequencer.sv
module tb_eq_gain_sequencer;
    localparam int TMO = 1023;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rdy_in = 1'b0;
    logic       rdy_eq = 1'b0;
    logic       sample_go;
    logic [2:0] gainb, gainh;
    logic       irq;

    eq_gain_sequencer_if wbif();

    eq_gain_sequencer #(.GAIN_W(3), .TIMEOUT(TMO), .CNT_W(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .RDYin     (rdy_in),
        .RDYeq     (rdy_eq),
        .sample_go (sample_go),
        .gainb     (gainb),
        .gainh     (gainh),
        .irq       (irq),
        .wb        (wbif.slave)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model state
    int m_gb, m_gh, m_tb, m_th, m_div, m_divcnt, m_cnt;
    bit m_ovr, m_tmo, m_irqen, m_bypass;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    function automatic int toward(input int g, input int t);
        if (g < t) return g + 1;
        if (g > t) return g - 1;
        return g;
    endfunction

    task automatic model_reset();
        m_gb = 0; m_gh = 0; m_tb = 0; m_th = 0; m_div = 1; m_divcnt = 1; m_cnt = 0;
        m_ovr = 0; m_tmo = 0; m_irqen = 0; m_bypass = 0;
    endtask

    // One completed sample: count, then one gain step per div completions.
    task automatic model_complete();
        m_cnt = (m_cnt + 1) % 65536;
        if (m_divcnt == 1) begin
            m_divcnt = m_div;
            m_gb = toward(m_gb, m_tb);
            m_gh = toward(m_gh, m_th);
        end else m_divcnt--;
        if (m_bypass) begin m_gb = m_tb; m_gh = m_th; end
    endtask

    function automatic logic [31:0] exp_status(input bit busy);
        return {21'd0, 3'(m_gh), 1'b0, 3'(m_gb), m_tmo, m_ovr,
                (m_gb != m_tb) || (m_gh != m_th), busy};
    endfunction

    task automatic wb_write(input logic [7:0] adr, input logic [31:0] dat);
        int n = 0;
        wbif.wb_stb_i = 1; wbif.wb_cyc_i = 1; wbif.wb_we_i = 1;
        wbif.wb_adr_i = {24'd0, adr}; wbif.wb_dat_i = dat;
        do begin tick(1); n++; end while (!wbif.wb_ack_o && n < 4);
        if (!wbif.wb_ack_o) check("wr_ack_timeout", 0, 1);
        wbif.wb_stb_i = 0; wbif.wb_cyc_i = 0; wbif.wb_we_i = 0;
        tick(1);
    endtask

    task automatic wb_read(input logic [7:0] adr, output logic [31:0] dat);
        int n = 0;
        wbif.wb_stb_i = 1; wbif.wb_cyc_i = 1; wbif.wb_we_i = 0;
        wbif.wb_adr_i = {24'd0, adr};
        do begin tick(1); n++; end while (!wbif.wb_ack_o && n < 4);
        if (!wbif.wb_ack_o) check("rd_ack_timeout", 0, 1);
        dat = wbif.wb_dat_o;
        wbif.wb_stb_i = 0; wbif.wb_cyc_i = 0;
        tick(1);
    endtask

    task automatic pulse_in(input logic exp_go);
        rdy_in = 1; tick(1); rdy_in = 0;
        check("sample_go", sample_go, exp_go);
    endtask

    task automatic pulse_eq();
        rdy_eq = 1; tick(1); rdy_eq = 0;
    endtask

    // Full sample: issue, datapath latency, completion, then gains one cycle later.
    task automatic do_sample(input int gap);
        pulse_in(1);
        tick(gap);
        pulse_eq();
        model_complete();
        tick(1);
        check("gainb", gainb, m_gb);
        check("gainh", gainh, m_gh);
    endtask

    logic [31:0] rv;

    initial begin
        wbif.wb_stb_i = 0; wbif.wb_cyc_i = 0; wbif.wb_we_i = 0;
        wbif.wb_adr_i = 0; wbif.wb_sel_i = 4'hF; wbif.wb_dat_i = 0;
        model_reset();
        tick(3);
        check("rst_go", sample_go, 0);
        check("rst_gainb", gainb, 0);
        check("rst_gainh", gainh, 0);
        check("rst_irq", irq, 0);
        check("rst_dat", wbif.wb_dat_o, 0);
        check("rst_ack", wbif.wb_ack_o, 0);
        reset = 0;
        tick(2);
        wb_read(8'h10, rv); check("rst_status", rv, 0);
        wb_read(8'h08, rv); check("rst_div", rv, 1);

        // div=2, tgt_b=5: gainb steps every second completion
        wb_write(8'h08, 2); m_div = 2; m_divcnt = 2;
        wb_write(8'h00, 5); m_tb = 5;
        for (int i = 0; i < 10; i++) begin
            do_sample(3);
            if (i == 0) begin tick(0); end
            tick(35);
        end
        check("gainb_final", gainb, 5);
        wb_read(8'h14, rv); check("count10", rv, 10);

        // Retarget mid-ramp with div=1
        wb_write(8'h08, 1); m_div = 1; m_divcnt = 1;
        wb_write(8'h04, 6); m_th = 6;
        for (int i = 0; i < 8 && m_gh != 4; i++) do_sample(2);
        check("gainh_at4", gainh, 4);
        wb_write(8'h04, 2); m_th = 2;
        for (int i = 0; i < 3; i++) do_sample(2);
        check("gainh_hold2", gainh, 2);
        wb_read(8'h10, rv); check("ramping_clear", rv[1], 0);
        check("status_retarget", rv, exp_status(0));

        // Overrun: second RDYin while waiting is dropped
        wb_write(8'h0C, 1); m_irqen = 1;
        pulse_in(1);
        tick(1); check("go_is_pulse", sample_go, 0);
        tick(3);
        pulse_in(0); m_ovr = 1;
        tick(1);
        check("irq_ovr", irq, 1);
        wb_read(8'h10, rv); check("status_ovr", rv, exp_status(1));
        pulse_eq(); model_complete(); tick(2);
        wb_write(8'h10, 32'h4); m_ovr = 0;
        tick(1);
        check("irq_cleared", irq, 0);

        // Timeout: no completion
        pulse_in(1);
        tick(TMO - 20);
        wb_read(8'h10, rv); check("pre_timeout", rv, exp_status(1));
        tick(60); m_tmo = 1;
        wb_read(8'h10, rv); check("status_tmo", rv, exp_status(0));
        wb_read(8'h14, rv); check("count_tmo", rv, m_cnt);
        check("irq_tmo", irq, 1);
        do_sample(4);
        wb_write(8'h10, 32'h8); m_tmo = 0;
        tick(1); check("irq_tmo_clr", irq, 0);

        // Spurious completion in IDLE is ignored
        pulse_eq(); tick(2);
        wb_read(8'h14, rv); check("spurious_eq", rv, m_cnt);

        // Invalid accesses and div=0
        wbif.wb_stb_i = 1; wbif.wb_cyc_i = 1; wbif.wb_we_i = 0; wbif.wb_adr_i = 32'h20;
        #1 check("ack_wait_state", wbif.wb_ack_o, 0);
        wbif.wb_stb_i = 0; wbif.wb_cyc_i = 0;
        tick(2);
        wb_read(8'h20, rv); check("bad_read", rv, 32'hFF);
        wb_write(8'h18, 32'h7);
        wb_read(8'h00, rv); check("bad_write_tgtb", rv, m_tb);
        wb_write(8'h08, 0); m_div = 1; m_divcnt = 1;
        wb_read(8'h08, rv); check("div0", rv, 1);
        wb_read(8'h20, rv);

        // Reset in the middle of WAIT
        pulse_in(1);
        tick(3);
        reset = 1; #1;
        check("mid_rst_gainb", gainb, 0);
        check("mid_rst_gainh", gainh, 0);
        check("mid_rst_dat", wbif.wb_dat_o, 0);
        check("mid_rst_irq", irq, 0);
        tick(1); reset = 0; model_reset(); tick(1);
        wb_read(8'h14, rv); check("mid_rst_count", rv, 0);
        wb_read(8'h10, rv); check("mid_rst_status", rv, 0);
        pulse_in(1); pulse_eq(); model_complete(); tick(2);

        // Randomized rounds against the model
        for (int r = 0; r < 6; r++) begin
            int d, n;
            m_tb = $urandom_range(0, 7); m_th = $urandom_range(0, 7);
            d = $urandom_range(0, 3);
            wb_write(8'h00, m_tb); wb_write(8'h04, m_th);
            wb_write(8'h08, d); m_div = (d == 0) ? 1 : d; m_divcnt = m_div;
            n = $urandom_range(3, 8);
            for (int k = 0; k < n; k++) begin
                do_sample($urandom_range(1, 15));
                tick($urandom_range(0, 4));
            end
            wb_read(8'h10, rv); check("rnd_status", rv, exp_status(0));
            wb_read(8'h14, rv); check("rnd_count", rv, m_cnt);
        end

        // Bypass: jump straight to targets
        wb_write(8'h0C, 2); m_bypass = 1;
        wb_write(8'h08, 4); m_div = 4; m_divcnt = 4;
        m_tb = 7; m_th = 1;
        wb_write(8'h00, 7); wb_write(8'h04, 1);
        do_sample(2);
        check("bypass_b", gainb, 7);
        check("bypass_h", gainh, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1);
    end
endmodule
